// File: rtl/boot_loader_pkg.sv
// ============================================================================
// Module   : boot_loader_pkg
// Purpose  : Shared states, command bytes and frame geometry for the boot loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package boot_loader_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_CSUM   = 3'd3;
    localparam logic [2:0] ST_VERIFY = 3'd4;
    localparam logic [2:0] ST_COMMIT = 3'd5;

    localparam logic [7:0] CMD_WRITE = 8'h57;  // "W"
    localparam logic [7:0] CMD_HALT  = 8'h48;  // "H"
    localparam logic [7:0] CMD_GO    = 8'h47;  // "G"
    localparam logic [7:0] CMD_CLR   = 8'h43;  // "C"

    // Payload bytes after the command byte: 4 address + 4 data, little-endian
    localparam int         FRAME_BYTES   = 8;
    localparam logic [3:0] ADDR_LAST_IDX = 4'd3;
    localparam logic [3:0] DATA_LAST_IDX = 4'd7;

endpackage

`default_nettype wire

// File: rtl/boot_frame_asm.sv
// ============================================================================
// Module   : boot_frame_asm
// Purpose  : Assembles frame payload bytes into addr/data, inter-byte timeout,
//            and XOR checksum when BOOT_LOADER_CHECKSUM_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module boot_frame_asm
    import boot_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        active_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    output logic [3:0]  idx_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic        timeout_o
`ifdef BOOT_LOADER_CHECKSUM_EN
    ,
    output logic        csum_ok_o
`endif
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [63:0]      frame_q, frame_d;
    logic [3:0]       idx_q, idx_d;
    logic [TMR_W-1:0] tmr_q;
    logic             take_w;

    assign take_w = active_i && valid_i && (idx_q < 4'(FRAME_BYTES));

    always_comb begin
        frame_d = frame_q;
        idx_d   = idx_q;
        if (!active_i) begin
            idx_d = '0;
        end else if (take_w) begin
            frame_d[{idx_q[2:0], 3'b000} +: 8] = byte_i;
            idx_d = idx_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            frame_q <= '0;
            idx_q   <= '0;
            tmr_q   <= '0;
        end else begin
            frame_q <= frame_d;
            idx_q   <= idx_d;
            tmr_q   <= (!active_i || valid_i) ? '0 : tmr_q + 1'b1;
        end
    end

    // Outputs see the byte arriving this cycle so the last byte can commit at once
    assign addr_o    = frame_d[31:0];
    assign data_o    = frame_d[63:32];
    assign idx_o     = idx_q;
    assign timeout_o = active_i && !valid_i && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !active_i) begin
            csum_q <= '0;
        end else if (take_w) begin
            csum_q <= csum_q ^ byte_i;
        end
    end

    assign csum_ok_o = (byte_i == csum_q);
`endif

endmodule

`default_nettype wire

// File: rtl/boot_loader_ctrl.sv
// ============================================================================
// Module   : boot_loader_ctrl
// Purpose  : UART command FSM, CPU halt/restart and RAM write-port arbitration.
//            Optional frame checksum: BOOT_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module boot_loader_ctrl
    import boot_loader_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT   = 32'h20000,
    parameter int          TIMEOUT_CYC  = 4096,
    parameter int          STARVE_MAX   = 32,
    parameter logic        RESET_HALTED = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    input  logic        cpu_mem_req_in,
    output logic        cpu_stall_out,
    output logic        cpu_halt_out,
    output logic        cpu_restart_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_data_out,
    output logic        mem_we_out,
    output logic        busy_out,
    output logic        err_out,
    output logic [15:0] words_out
);

    logic [2:0]  state_q, state_d;
    logic        halt_q, halt_d, restart_q, restart_d, err_q, err_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] words_q, words_d;
    logic [31:0] maddr_q, maddr_d, mdata_q, mdata_d;
    logic [3:0]  idx_w;
    logic [31:0] addr_w, data_w;
    logic        timeout_w, active_w, grant_w, starve_w, commit_w, we_w;

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic csum_ok_w, csum_ok_q, csum_ok_d;
    assign active_w = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
`else
    assign active_w = (state_q == ST_ADDR) || (state_q == ST_DATA);
`endif

    boot_frame_asm #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_asm (
        .clk_i     (clk_in),
        .rst_n_i   (rst_in),
        .active_i  (active_w),
        .valid_i   (rx_valid_in),
        .byte_i    (rx_data_in),
        .idx_o     (idx_w),
        .addr_o    (addr_w),
        .data_o    (data_w),
        .timeout_o (timeout_w)
`ifdef BOOT_LOADER_CHECKSUM_EN
        ,
        .csum_ok_o (csum_ok_w)
`endif
    );

    // CPU owns the port unless halted or idle; loader forces a stall once starved
    assign commit_w = (state_q == ST_COMMIT);
    assign grant_w  = halt_q || !cpu_mem_req_in;
    assign starve_w = (wait_q == 8'(STARVE_MAX));
    assign we_w     = commit_w && (grant_w || starve_w);

    always_comb begin
        state_d   = state_q;
        halt_d    = halt_q;
        restart_d = 1'b0;
        err_d     = err_q;
        wait_d    = '0;
        words_d   = words_q;
        maddr_d   = maddr_q;
        mdata_d   = mdata_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
        csum_ok_d = csum_ok_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_valid_in) begin
                    case (rx_data_in)
                        CMD_WRITE: state_d = ST_ADDR;
                        CMD_HALT:  halt_d  = 1'b1;
                        CMD_GO: begin
                            halt_d    = 1'b0;
                            restart_d = 1'b1;
                        end
                        CMD_CLR:   err_d   = 1'b0;
                        default:   ;
                    endcase
                end
            end
            ST_ADDR: begin
                if (timeout_w) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (rx_valid_in && (idx_w == ADDR_LAST_IDX)) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (timeout_w) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (rx_valid_in && (idx_w == DATA_LAST_IDX)) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    if (addr_w >= ADDR_LIMIT) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_COMMIT;
                        maddr_d = {addr_w[31:2], 2'b00};
                        mdata_d = data_w;
                    end
`endif
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (timeout_w) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (rx_valid_in) begin
                    state_d   = ST_VERIFY;
                    csum_ok_d = csum_ok_w;
                end
            end
            ST_VERIFY: begin
                if (rx_valid_in) err_d = 1'b1;
                if (!csum_ok_q || (addr_w >= ADDR_LIMIT)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_COMMIT;
                    maddr_d = {addr_w[31:2], 2'b00};
                    mdata_d = data_w;
                end
            end
`endif
            ST_COMMIT: begin
                if (rx_valid_in) err_d = 1'b1;
                if (we_w) begin
                    state_d = ST_IDLE;
                    words_d = words_q + 16'd1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            halt_q    <= RESET_HALTED;
            restart_q <= 1'b0;
            err_q     <= 1'b0;
            wait_q    <= '0;
            words_q   <= '0;
            maddr_q   <= '0;
            mdata_q   <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_ok_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            halt_q    <= halt_d;
            restart_q <= restart_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
            words_q   <= words_d;
            maddr_q   <= maddr_d;
            mdata_q   <= mdata_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_ok_q <= csum_ok_d;
`endif
        end
    end

    assign cpu_stall_out   = commit_w && starve_w && !grant_w;
    assign cpu_halt_out    = halt_q;
    assign cpu_restart_out = restart_q;
    assign mem_addr_out    = maddr_q;
    assign mem_data_out    = mdata_q;
    assign mem_we_out      = we_w;
    assign busy_out        = (state_q != ST_IDLE);
    assign err_out         = err_q;
    assign words_out       = words_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_loader_ctrl.sv
// ============================================================================
// Module   : tb_boot_loader_ctrl
// Purpose  : Self-checking bench for boot_loader_ctrl with a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_boot_loader_ctrl;

    localparam logic [31:0] LIMIT = 32'h20000;
    localparam int          TO    = 64;
    localparam int          SM    = 8;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam int          LAT   = 2;
`else
    localparam int          LAT   = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic [7:0]  rx_data_in = 8'h00;
    logic        rx_valid_in = 1'b0;
    logic        cpu_mem_req_in = 1'b0;
    logic        cpu_stall_out, cpu_halt_out, cpu_restart_out, mem_we_out, busy_out, err_out;
    logic [31:0] mem_addr_out, mem_data_out;
    logic [15:0] words_out;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          restarts = 0;
    logic [15:0] exp_words = 16'd0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        s;
        int          c;
    } wr_t;
    wr_t wq[$];

    always #5 clk = ~clk;

    boot_loader_ctrl #(
        .ADDR_LIMIT   (LIMIT),
        .TIMEOUT_CYC  (TO),
        .STARVE_MAX   (SM),
        .RESET_HALTED (1'b1)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst_in),
        .rx_data_in      (rx_data_in),
        .rx_valid_in     (rx_valid_in),
        .cpu_mem_req_in  (cpu_mem_req_in),
        .cpu_stall_out   (cpu_stall_out),
        .cpu_halt_out    (cpu_halt_out),
        .cpu_restart_out (cpu_restart_out),
        .mem_addr_out    (mem_addr_out),
        .mem_data_out    (mem_data_out),
        .mem_we_out      (mem_we_out),
        .busy_out        (busy_out),
        .err_out         (err_out),
        .words_out       (words_out)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we_out === 1'b1) wq.push_back('{mem_addr_out, mem_data_out, cpu_stall_out, cyc});
        if (cpu_restart_out === 1'b1) restarts <= restarts + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_in  = b;
        rx_valid_in = 1'b1;
        @(posedge clk);
        #1;
        rx_valid_in = 1'b0;
    endtask

    // Returns the cycle number of the first COMMIT cycle (if the frame is accepted)
    task automatic send_frame(input logic [31:0] a, input logic [31:0] d, input bit corrupt, output int c0);
        logic [63:0] fr;
        logic [7:0]  cs;
        fr = {d, a};
        cs = 8'h00;
        send_byte(8'h57);
        for (int i = 0; i < 8; i++) begin
            idle(int'($urandom_range(0, 2)));
            cs = cs ^ fr[i*8 +: 8];
            send_byte(fr[i*8 +: 8]);
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        idle(int'($urandom_range(0, 2)));
        send_byte(corrupt ? (cs ^ 8'h01) : cs);
        idle(1);
`else
        if (corrupt) cs = 8'h00;
`endif
        c0 = cyc;
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        idle(3);
        @(negedge clk);
        if (cpu_halt_out !== 1'b1) begin n_fail++; $display("FAIL reset_halt: got %b exp 1", cpu_halt_out); end
        n_cmp++;
        if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy_out); end
        n_cmp++;
        if (err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", err_out); end
        n_cmp++;
        if ({mem_we_out, cpu_stall_out, cpu_restart_out} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b exp 000", {mem_we_out, cpu_stall_out, cpu_restart_out});
        end
        n_cmp++;
        if (words_out !== 16'd0) begin n_fail++; $display("FAIL reset_words: got %0d exp 0", words_out); end
        n_cmp++;
        if ({mem_addr_out, mem_data_out} !== 64'd0) begin
            n_fail++; $display("FAIL reset_mem: got %h %h exp 0 0", mem_addr_out, mem_data_out);
        end
        n_cmp++;
        @(posedge clk);
        #1;
        rst_in = 1'b1;
        idle(2);
    endtask

    task automatic test_halted_write;
        logic [31:0] a, d;
        int c0;
        for (int i = 0; i < 5; i++) begin
            a  = (i == 0) ? 32'h100 : 32'($urandom_range(0, int'(LIMIT) - 1));
            d  = (i == 0) ? 32'hDEADBEEF : 32'($urandom);
            cpu_mem_req_in = 1'($urandom_range(0, 1));
            wq.delete();
            send_frame(a, d, 1'b0, c0);
            idle(SM + 3);
            exp_words = exp_words + 16'd1;
            if (wq.size() !== 1) begin n_fail++; $display("FAIL halted_count: got %0d exp 1", wq.size()); end
            n_cmp++;
            if (wq.size() >= 1) begin
                if (wq[0].a !== {a[31:2], 2'b00} || wq[0].d !== d) begin
                    n_fail++; $display("FAIL halted_wr: got %h/%h exp %h/%h", wq[0].a, wq[0].d, {a[31:2], 2'b00}, d);
                end
                n_cmp++;
                if (wq[0].c !== c0 || wq[0].s !== 1'b0) begin
                    n_fail++; $display("FAIL halted_lat: got cyc %0d stall %b exp cyc %0d stall 0", wq[0].c, wq[0].s, c0);
                end
                n_cmp++;
            end
            if (words_out !== exp_words) begin n_fail++; $display("FAIL halted_words: got %0d exp %0d", words_out, exp_words); end
            n_cmp++;
        end
        cpu_mem_req_in = 1'b0;
    endtask

    task automatic test_starve;
        logic [31:0] a, d;
        bit          pat [0:SM];
        int          c0, j_exp;
        bit          s_exp;
        restarts = 0;
        send_byte(8'h47);
        idle(3);
        if (cpu_halt_out !== 1'b0 || restarts !== 1) begin
            n_fail++; $display("FAIL go: got halt %b pulses %0d exp 0 1", cpu_halt_out, restarts);
        end
        n_cmp++;
        for (int r = 0; r < 6; r++) begin
            a = 32'($urandom_range(0, int'(LIMIT) - 1));
            d = 32'($urandom);
            j_exp = SM;
            s_exp = 1'b1;
            for (int j = 0; j <= SM; j++) begin
                pat[j] = (r < 2) ? 1'b1 : ($urandom_range(0, 5) != 0);
                if (!pat[j] && s_exp) begin j_exp = j; s_exp = 1'b0; end
            end
            cpu_mem_req_in = 1'b1;
            wq.delete();
            send_frame(a, d, 1'b0, c0);
            for (int j = 0; j <= SM; j++) begin
                cpu_mem_req_in = pat[j];
                if (r == 1 && j == 0) send_byte(8'hA5);
                else idle(1);
            end
            cpu_mem_req_in = 1'b0;
            idle(2);
            exp_words = exp_words + 16'd1;
            if (wq.size() !== 1) begin n_fail++; $display("FAIL starve_count: got %0d exp 1", wq.size()); end
            n_cmp++;
            if (wq.size() >= 1) begin
                if (wq[0].c !== c0 + j_exp || wq[0].s !== s_exp || wq[0].d !== d) begin
                    n_fail++;
                    $display("FAIL starve_wr: got cyc %0d stall %b data %h exp cyc %0d stall %b data %h",
                             wq[0].c - c0, wq[0].s, wq[0].d, j_exp, s_exp, d);
                end
                n_cmp++;
            end
            if (err_out !== (r == 1)) begin n_fail++; $display("FAIL commit_byte_err: got %b exp %b", err_out, (r == 1)); end
            n_cmp++;
            if (r == 1) begin
                send_byte(8'h43);
                idle(1);
            end
        end
        if (words_out !== exp_words) begin n_fail++; $display("FAIL starve_words: got %0d exp %0d", words_out, exp_words); end
        n_cmp++;
    endtask

    task automatic test_limit;
        logic [31:0] a;
        int c0;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       a = LIMIT;
                1:       a = LIMIT - 32'd4;
                2:       a = LIMIT + 32'($urandom_range(1, 1 << 20));
                default: a = 32'hFFFF_FFFC;
            endcase
            wq.delete();
            send_frame(a, 32'($urandom), 1'b0, c0);
            idle(3);
            if (a < LIMIT) exp_words = exp_words + 16'd1;
            if (wq.size() !== ((a < LIMIT) ? 1 : 0) || err_out !== (a >= LIMIT)) begin
                n_fail++; $display("FAIL limit_%0d: got writes %0d err %b exp %0d %b", i, wq.size(), err_out,
                                   (a < LIMIT) ? 1 : 0, (a >= LIMIT));
            end
            n_cmp++;
            send_byte(8'h43);
            idle(1);
            if (err_out !== 1'b0) begin n_fail++; $display("FAIL clear_err: got %b exp 0", err_out); end
            n_cmp++;
        end
        if (words_out !== exp_words) begin n_fail++; $display("FAIL limit_words: got %0d exp %0d", words_out, exp_words); end
        n_cmp++;
    endtask

    task automatic test_timeout;
        logic [31:0] a, d;
        int c0;
        wq.delete();
        send_byte(8'h57);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        idle(TO - 2);
        if (busy_out !== 1'b1) begin n_fail++; $display("FAIL timeout_early: got busy %b exp 1", busy_out); end
        n_cmp++;
        idle(4);
        if (busy_out !== 1'b0 || err_out !== 1'b1 || wq.size() !== 0) begin
            n_fail++; $display("FAIL timeout_abort: got busy %b err %b writes %0d exp 0 1 0", busy_out, err_out, wq.size());
        end
        n_cmp++;
        send_byte(8'h43);
        a = 32'($urandom_range(0, int'(LIMIT) - 1));
        d = 32'($urandom);
        send_frame(a, d, 1'b0, c0);
        idle(3);
        exp_words = exp_words + 16'd1;
        if (wq.size() !== 1 || err_out !== 1'b0) begin
            n_fail++; $display("FAIL timeout_recover: got writes %0d err %b exp 1 0", wq.size(), err_out);
        end else if (wq[0].a !== {a[31:2], 2'b00} || wq[0].d !== d || wq[0].c !== c0) begin
            n_fail++; $display("FAIL timeout_recover_wr: got %h/%h exp %h/%h", wq[0].a, wq[0].d, {a[31:2], 2'b00}, d);
        end
        n_cmp++;
    endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        int c0;
        for (int i = 0; i < 4; i++) begin
            wq.delete();
            send_frame(32'($urandom_range(0, int'(LIMIT) - 1)), 32'($urandom), i[0], c0);
            idle(3);
            if (!i[0]) exp_words = exp_words + 16'd1;
            if (wq.size() !== (i[0] ? 0 : 1) || err_out !== i[0]) begin
                n_fail++; $display("FAIL csum_%0d: got writes %0d err %b", i, wq.size(), err_out);
            end
            n_cmp++;
            send_byte(8'h43);
        end
    endtask
`endif

    task automatic test_halt_and_reset;
        send_byte(8'h48);
        @(negedge clk);
        if (cpu_halt_out !== 1'b1) begin n_fail++; $display("FAIL halt_cmd: got %b exp 1", cpu_halt_out); end
        n_cmp++;
        #1;
        restarts = 0;
        send_byte(8'h47);
        idle(3);
        if (cpu_halt_out !== 1'b0 || restarts !== 1) begin
            n_fail++; $display("FAIL go_cmd: got halt %b pulses %0d exp 0 1", cpu_halt_out, restarts);
        end
        n_cmp++;
        wq.delete();
        send_byte(8'h57);
        send_byte(8'h12);
        send_byte(8'h34);
        rst_in = 1'b0;
        idle(2);
        exp_words = 16'd0;
        if (cpu_halt_out !== 1'b1 || busy_out !== 1'b0 || words_out !== exp_words) begin
            n_fail++; $display("FAIL mid_reset: got halt %b busy %b words %0d exp 1 0 0", cpu_halt_out, busy_out, words_out);
        end
        n_cmp++;
        rst_in = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(8'h11);
        idle(SM + 3);
        if (wq.size() !== 0 || busy_out !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: got writes %0d busy %b exp 0 0", wq.size(), busy_out);
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_halted_write();
        test_starve();
        test_limit();
        test_timeout();
`ifdef BOOT_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_halt_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
